// File: rtl/reg_readback_arb.sv
// Two-requester round-robin arbiter for a shared 32-entry readback memory.
// Optional post-reset memory clear is enabled with the REGRB_CLEAR_EN macro.
module reg_readback_arb #(
    parameter int WID = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           a_req_i,
    input  logic           a_we_i,
    input  logic [4:0]     a_adr_i,
    input  logic [WID-1:0] a_dat_i,
    input  logic           b_req_i,
    input  logic           b_we_i,
    input  logic [4:0]     b_adr_i,
    input  logic [WID-1:0] b_dat_i,
    output logic           a_ack_o,
    output logic           b_ack_o,
    output logic [WID-1:0] a_dat_o,
    output logic [WID-1:0] b_dat_o,
    output logic           busy_o,
    output logic           mem_wce_o,
    output logic           mem_we_o,
    output logic [4:0]     mem_adr_o,
    output logic [WID-1:0] mem_dat_o,
    input  logic [WID-1:0] mem_dat_i
);

    typedef enum logic [1:0] {
`ifdef REGRB_CLEAR_EN
        ST_CLEAR = 2'd3,
`endif
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

`ifdef REGRB_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t           state_reg, state_next;
    logic             we_reg, we_next;
    logic [4:0]       adr_reg, adr_next;
    logic [WID-1:0]   dat_reg, dat_next;
    logic             grant_reg, grant_next;   // 0 = A, 1 = B
`ifdef REGRB_CLEAR_EN
    logic [4:0]       clr_cnt_reg, clr_cnt_next;
`endif

    logic [1:0]            req_vec;
    logic [1:0]            we_vec;
    logic [1:0][4:0]       adr_vec;
    logic [1:0][WID-1:0]   dat_vec;
    logic [1:0]            ack_vec;
    logic [1:0][WID-1:0]   rd_dat;
    logic                  win_b;

    assign req_vec = {b_req_i, a_req_i};
    assign we_vec  = {b_we_i, a_we_i};
    assign adr_vec = {b_adr_i, a_adr_i};
    assign dat_vec = {b_dat_i, a_dat_i};

    // B wins when it is alone, or when both ask and A was granted last.
    assign win_b = b_req_i & (~a_req_i | ~grant_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RESET_STATE;
            we_reg      <= 1'b0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            grant_reg   <= 1'b1;
`ifdef REGRB_CLEAR_EN
            clr_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            we_reg      <= we_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
            grant_reg   <= grant_next;
`ifdef REGRB_CLEAR_EN
            clr_cnt_reg <= clr_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        we_next    = we_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        grant_next = grant_reg;
        mem_wce_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_adr_o  = '0;
        mem_dat_o  = '0;
`ifdef REGRB_CLEAR_EN
        clr_cnt_next = clr_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    we_next    = we_vec[win_b];
                    adr_next   = adr_vec[win_b];
                    dat_next   = dat_vec[win_b];
                    grant_next = win_b;
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                mem_adr_o = adr_reg;
                if (we_reg) begin
                    mem_wce_o = 1'b1;
                    mem_we_o  = 1'b1;
                    mem_dat_o = dat_reg;
                end
                state_next = ST_ACK;
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
`ifdef REGRB_CLEAR_EN
            ST_CLEAR: begin
                mem_wce_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_adr_o    = clr_cnt_reg;
                clr_cnt_next = clr_cnt_reg + 5'd1;
                if (clr_cnt_reg == 5'd31) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic SEL = (gi == 1);
            logic [WID-1:0] rd_dat_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_dat_reg <= '0;
                end else if (state_reg == ST_SERVE && !we_reg && grant_reg == SEL) begin
                    rd_dat_reg <= mem_dat_i;
                end
            end

            assign rd_dat[gi] = rd_dat_reg;
            // A reset landing on the ACK cycle abandons the transaction, so no pulse.
            assign ack_vec[gi] = (state_reg == ST_ACK) && (grant_reg == SEL) && !rst_i;
        end
    endgenerate

    assign a_ack_o = ack_vec[0];
    assign b_ack_o = ack_vec[1];
    assign a_dat_o = rd_dat[0];
    assign b_dat_o = rd_dat[1];
    assign busy_o  = (state_reg != ST_IDLE);

endmodule
